// File: rtl/ext_arb.sv
// ext_arb -- shared immediate / jump-offset extension unit for the decode stage.
//
// Two requesters share one extender. Port 0 carries an I-type immediate with a
// 2-bit extend mode, port 1 carries a J-type 26-bit jump index. The winner of
// arbitration is extended to N+1 bits and captured in a one-entry output
// register that feeds the ID/EX operand mux.
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both high on the same port (or on the output side). Ready never depends on
// the same port's payload. Requesters keep valid and payload stable until
// accepted.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in0_valid/imm/mode      port 0 request (16-bit immediate, extend mode)
//   in0_ready               port 0 accepted this cycle
//   in1_valid/idx           port 1 request (26-bit jump index)
//   in1_ready               port 1 accepted this cycle
//   out_valid/data/id       result register contents and originating port
//   out_ready               consumer takes the result this cycle
//
// Parameters:
//   N        MSB index of the data word (result is N+1 bits)
//   MAXWAIT  lost-arbitration cycles before port 0 is force-granted
//
// Build option: EXT_ARB_RR_EN selects round-robin arbitration instead of
// fixed priority with the port 0 starvation guard.

module ext_arb #(
    parameter int N       = 31,
    parameter int MAXWAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in0_valid,
    input  logic [15:0] in0_imm,
    input  logic [1:0]  in0_mode,
    output logic        in0_ready,
    input  logic        in1_valid,
    input  logic [25:0] in1_idx,
    output logic        in1_ready,
    output logic        out_valid,
    output logic [N:0]  out_data,
    output logic        out_id,
    input  logic        out_ready
);

    // Extend-mode encodings; any other value selects sign extension.
    localparam logic [1:0] EXT_UNSI = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;
    localparam logic [1:0] EXT_SA   = 2'd3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic       slot_free;
    logic       grant0, grant1;
    logic       xfer0, xfer1, xfer;
    logic [N:0] ext0, ext1;

    // ---------------------------------------------------------------
    // Arbitration
    // ---------------------------------------------------------------
`ifdef EXT_ARB_RR_EN
    logic rr_ptr;

    always_comb begin
        grant0 = in0_valid & (~in1_valid | ~rr_ptr);
        grant1 = in1_valid & ~grant0;
    end

    // After a transfer the port that did not move gets priority next time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (xfer) begin
            rr_ptr <= xfer0;
        end
    end
`else
    localparam int WW = $clog2(MAXWAIT + 1);

    logic [WW-1:0] wait_cnt;
    logic          starved;

    // Port 1 normally wins; a port 0 that has lost MAXWAIT times in a row
    // takes the next grant.
    always_comb begin
        starved = (wait_cnt == WW'(MAXWAIT));
        grant1  = in1_valid & ~(in0_valid & starved);
        grant0  = in0_valid & ~grant1;
    end

    // Counts only cycles where port 1 actually moved past a waiting port 0,
    // so an output stall does not age the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (xfer0) begin
            wait_cnt <= '0;
        end else if (in0_valid && xfer1 && !starved) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`endif

    // ---------------------------------------------------------------
    // Handshake
    // ---------------------------------------------------------------
    // rst_n gates the readies so nothing is accepted while reset is held.
    always_comb begin
        slot_free = (state_q == EMPTY) | out_ready;
        in0_ready = grant0 & slot_free & rst_n;
        in1_ready = grant1 & slot_free & rst_n;
        xfer0     = in0_valid & in0_ready;
        xfer1     = in1_valid & in1_ready;
        xfer      = xfer0 | xfer1;
    end

    // ---------------------------------------------------------------
    // Extension
    // ---------------------------------------------------------------
    always_comb begin
        case (in0_mode)
            EXT_UNSI: ext0 = (N+1)'(in0_imm);
            EXT_LUI:  ext0 = (N+1)'({in0_imm, 16'h0000});
            EXT_SA:   ext0 = (N+1)'(in0_imm[10:6]);
            default:  ext0 = (N+1)'($signed(in0_imm));
        endcase
        // Sign-extend first, then word-align; the shift drops the top bits.
        ext1 = (N+1)'($signed(in1_idx)) << 2;
    end

    // ---------------------------------------------------------------
    // Output register state machine
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A new transfer while FULL and drained refills the slot on the same
    // edge, so back-to-back results flow with no bubble.
    always_comb begin
        state_d   = state_q;
        out_valid = (state_q == FULL);
        if (xfer) begin
            state_d = FULL;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_id   <= 1'b0;
        end else if (xfer0) begin
            out_data <= ext0;
            out_id   <= 1'b0;
        end else if (xfer1) begin
            out_data <= ext1;
            out_id   <= 1'b1;
        end
    end

endmodule
